// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled 8N1 UART receiver feeding a first-word-fall-through FIFO; define UART_RX_PARITY_EN for 8E1 with parity checking
module uart_rx_fifo #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic                          UART_RX,
  input  logic                          rd,
  input  logic                          clr,
  output logic [7:0]                    rdata,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          overrun,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          irq
);
  localparam int DIV = CLK_HZ / (BAUD * 16);
  localparam int TW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t          state_q, state_d;
  logic            s1_q, rxs_q, rxp_q;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [3:0]      scnt_q, scnt_d;
  logic [2:0]      bcnt_q, bcnt_d;
  logic [7:0]      data_q, data_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovr_q, fe_q;
  logic            tick, mid, last, push, fe_set, pop, full, wr;
  assign tick = tcnt_q == TW'(DIV - 1);
  assign mid  = tick && scnt_q == 4'd7;
  assign last = tick && scnt_q == 4'hf;
`ifdef UART_RX_PARITY_EN
  logic pe_q, pe_set;
  // sticky parity error, set wins over clear
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) pe_q <= 1'b0;
    else pe_q <= pe_set || (pe_q && !clr);
  end
  assign parity_err = pe_q;
`else
  assign parity_err = 1'b0;
`endif
  // receive FSM next state plus bit-timing counters and data shifter
  always_comb begin
    state_d = state_q;
    tcnt_d  = tick ? '0 : tcnt_q + TW'(1);
    scnt_d  = tick ? scnt_q + 4'd1 : scnt_q;
    bcnt_d  = bcnt_q;
    data_d  = data_q;
    push    = 1'b0;
    fe_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    pe_set  = 1'b0;
`endif
    case (state_q)
      IDLE: if (rxp_q && !rxs_q) begin
        state_d = START;
        tcnt_d  = '0;
        scnt_d  = '0;
        bcnt_d  = '0;
      end
      START: if (mid) begin
        state_d = rxs_q ? IDLE : DATA;
        scnt_d  = '0;
      end
      DATA: if (last) begin
        data_d = {rxs_q, data_q[7:1]};
        bcnt_d = bcnt_q + 3'd1;
        if (bcnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (last) begin
        pe_set  = ^{data_q, rxs_q};
        state_d = pe_set ? IDLE : STOP;
      end
`endif
      STOP: if (last) begin
        push    = rxs_q;
        fe_set  = !rxs_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign pop   = rd && cnt_q != '0;
  assign full  = cnt_q == CW'(FIFO_DEPTH);
  assign wr    = push && (!full || pop);
  assign cnt_d = cnt_q + CW'(wr) - CW'(pop);
  // line synchronizer, FSM state, counters, FIFO pointers and sticky flags
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      s1_q    <= 1'b1;
      rxs_q   <= 1'b1;
      rxp_q   <= 1'b1;
      state_q <= IDLE;
      tcnt_q  <= '0;
      scnt_q  <= '0;
      bcnt_q  <= '0;
      data_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      s1_q    <= UART_RX;
      rxs_q   <= s1_q;
      rxp_q   <= rxs_q;
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
      data_q  <= data_d;
      wptr_q  <= wr ? wptr_q + AW'(1) : wptr_q;
      rptr_q  <= pop ? rptr_q + AW'(1) : rptr_q;
      cnt_q   <= cnt_d;
      ovr_q   <= (push && !wr) || (ovr_q && !clr);
      fe_q    <= fe_set || (fe_q && !clr);
    end
  end
  // FIFO storage; left unreset because rdata is masked while empty
  always_ff @(posedge sysclk) begin
    if (wr) mem_q[wptr_q] <= data_q;
  end
  assign rx_valid  = cnt_q != '0;
  assign rx_count  = cnt_q;
  assign rdata     = rx_valid ? mem_q[rptr_q] : 8'h00;
  assign overrun   = ovr_q;
  assign frame_err = fe_q;
  assign irq       = rx_valid;
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

UART receive unit with an integrated receive FIFO, sitting directly upstream of the memory-mapped peripheral block on the MEM-stage data bus. It oversamples the asynchronous `UART_RX` line at 16x the baud rate, assembles 8N1 frames, and buffers received bytes in a first-word-fall-through FIFO. The peripheral block pops bytes on CPU loads and forwards `irq` to the pipeline's interrupt logic.

## Interface
- `CLK_HZ`, default 100_000_000, system clock frequency in Hz.
- `BAUD`, default 9600, line baud rate. `DIV = CLK_HZ/(BAUD*16)`, integer division, must be ≥ 2.
- `FIFO_DEPTH`, default 4, number of FIFO entries; power of two, ≥ 2.
- `sysclk`  in  1  single system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `UART_RX`  in  1  asynchronous serial input; idles high.
- `rd`  in  1  pop strobe; one byte is popped per cycle while high; ignored when the FIFO is empty.
- `clr`  in  1  clears the sticky error flags.
- `rdata`  out  8  FIFO head byte; `8'h00` when empty.
- `rx_valid`  out  1  FIFO is non-empty.
- `rx_count`  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- `overrun`  out  1  sticky: a byte was dropped because the FIFO was full.
- `frame_err`  out  1  sticky: a stop bit was sampled as 0.
- `parity_err`  out  1  sticky parity error; constant 0 unless `UART_RX_PARITY_EN` is defined.
- `irq`  out  1  equal to `rx_valid`.

## Operation
- **Synchronizer:** `UART_RX` passes through two flops, both reset to 1. All line logic uses the synchronized value `rxs`.
- **Tick generator:** a counter runs 0..DIV-1 and emits `tick` on DIV-1. It is forced to 0 on start-bit detection so that sampling phase aligns to the falling edge.
- **Sample counter:** a 4-bit counter `scnt` counts ticks within the current bit.
- **FSM states:** IDLE, START, DATA, PARITY (present only with the macro), STOP.
  - IDLE: a `rxs` 1→0 transition clears `scnt` and the tick counter, then moves to START.
  - START: when `scnt` reaches 7 on a tick (mid-bit), sample `rxs`.
    - 1: false start; return to IDLE.
    - 0: clear `scnt` and go to DATA.
  - DATA: on every 16th tick, shift `rxs` into the data register LSB-first. After the 8th bit, go to PARITY if enabled, otherwise STOP.
  - STOP: on the 16th tick, sample `rxs`.
    - 1: push the byte.
    - 0: set `frame_err` and discard the byte.
    - In both cases return to IDLE immediately (mid stop bit), so back-to-back frames are accepted.
- **FIFO:** circular buffer with read and write pointers plus `rx_count`; pointers wrap modulo `FIFO_DEPTH`. `rdata` is the head entry, read combinationally.
- **FIFO boundary cases:**
  - Push while full, no pop: byte dropped, `overrun` set, contents unchanged.
  - Push and pop in the same cycle when full: pop then push; `rx_count` unchanged; no overrun.
  - Push and pop in the same cycle when empty: the pop is ignored and the push is stored (`rx_count` becomes 1).
  - `rd` while empty: no effect.
- **Sticky flags:** cleared by `clr`. If set and `clr` occur in the same cycle, set wins.

## Timing
- **Reset values:** `rdata=0`, `rx_valid=0`, `rx_count=0`, `overrun=0`, `frame_err=0`, `parity_err=0`, `irq=0`; FSM in IDLE; pointers 0; counters 0.
- **Reset mid-frame:** the partial byte is lost, the FIFO is emptied, and the FSM returns to IDLE.
- **Input delay:** 2 cycles from a `UART_RX` edge to `rxs`.
- **Start-bit sampling:** the start bit is sampled 8×DIV cycles after `rxs` falls. Each data bit is sampled 16×DIV cycles after the previous sample.
- **Push latency:** `rx_valid`, `rx_count` and `rdata` update on the clock edge following the stop-bit sample tick (1 cycle).
- **Pop latency:** `rdata` shows the next entry on the edge after the `rd` cycle. `rx_count` decrements on the same edge.

## Configuration
- `UART_RX_PARITY_EN`: when defined, the frame is 8E1.
  - PARITY state samples the 9th bit 16 ticks after the last data bit.
  - If the XOR of the 8 data bits and the parity bit is 1, set `parity_err` and discard the byte. Otherwise go to STOP.
  - When undefined: frame is 8N1, the PARITY state does not exist, and `parity_err` is tied to 0.

## Test plan
All scenarios use `CLK_HZ=1_600_000`, `BAUD=10_000` (DIV=10, 160 cycles per bit) and `FIFO_DEPTH=4`.

- **Single byte:** send 0xA5 with stop=1 → `rx_valid=1`, `irq=1`, `rdata=0xA5`, `rx_count=1`. A 1-cycle `rd` → `rx_count=0`, `rdata=0x00`.
- **Glitch:** drive `UART_RX` low for 40 cycles, then high → FSM returns to IDLE, `rx_count` stays 0, no flags set. A following 0x5A frame is received correctly.
- **Framing error:** send 0x3C with stop=0 → `frame_err=1`, `rx_count=0`. Pulse `clr` → `frame_err=0`.
- **Overrun:** send 0x01..0x05 back-to-back with no reads → `rx_count=4`, `overrun=1`. Four reads return 01, 02, 03, 04.
- **Full FIFO, simultaneous push and pop:** with the FIFO full, assert `rd` on the push cycle → `rx_count` stays 4, `overrun` stays 0, head advances.
- **Reset mid-frame, and parity (macro builds):** assert `reset` during data bit 3 → all outputs 0; the next full frame 0x81 is received. With the macro, 0xA5 sent with parity bit 1 → `parity_err=1`, byte discarded.
